// File: rtl/rule_set_intersect_pkg.sv
// Shared constants, slot/state types and slot-extract helper for rule_set_intersect.
// Sets are NUM_RULE_ID slots of {valid,id}, slot 0 in the MSBs.
package rule_set_intersect_pkg;

  localparam int NUM_RULE_ID   = 8;
  localparam int RULE_ID_WIDTH = 3;
  localparam int SLOT_WIDTH    = RULE_ID_WIDTH + 1;
  localparam int SET_WIDTH     = NUM_RULE_ID * SLOT_WIDTH;
  localparam int PTR_WIDTH     = RULE_ID_WIDTH + 1;
  localparam int STAT_WIDTH    = 32;

  // Pointer value that marks a set as fully walked.
  localparam logic [PTR_WIDTH-1:0] PTR_END   = PTR_WIDTH'(NUM_RULE_ID);
  localparam logic [SET_WIDTH-1:0] EMPTY_SET = '0;

  typedef struct packed {
    logic                     valid;
    logic [RULE_ID_WIDTH-1:0] id;
  } slot_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    MERGE = 2'd1,
    DONE  = 2'd2
  } state_e;

  function automatic slot_t get_slot(input logic [SET_WIDTH-1:0]     set_v,
                                     input logic [RULE_ID_WIDTH-1:0] k);
    logic [SET_WIDTH-1:0] shifted;
    shifted = set_v >> (SLOT_WIDTH * (NUM_RULE_ID - 1 - int'(k)));
    return slot_t'(shifted[SLOT_WIDTH-1:0]);
  endfunction

endpackage

// File: rtl/rule_set_slot_mux.sv
// Selects slot idx_i of a packed rule-ID set and returns it as {valid,id}.
module rule_set_slot_mux
  import rule_set_intersect_pkg::*;
(
  input  logic [SET_WIDTH-1:0]     set_i,
  input  logic [RULE_ID_WIDTH-1:0] idx_i,
  output slot_t                    slot_o
);

  assign slot_o = get_slot(set_i, idx_i);

endmodule

// File: rtl/rule_set_intersect.sv
// Intersects two sorted rule-ID sets with a one-step-per-clock merge walk and
// reports the lowest common ID. Optional counters under RULE_SET_STATS_EN.
module rule_set_intersect
  import rule_set_intersect_pkg::*;
(
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [SET_WIDTH-1:0]     set_a,
  input  logic [SET_WIDTH-1:0]     set_b,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [SET_WIDTH-1:0]     out_set,
  output logic                     best_valid,
`ifdef RULE_SET_STATS_EN
  output logic [RULE_ID_WIDTH-1:0] best_id,
  input  logic                     stat_clr,
  output logic [STAT_WIDTH-1:0]    stat_pairs,
  output logic [STAT_WIDTH-1:0]    stat_nomatch
`else
  output logic [RULE_ID_WIDTH-1:0] best_id
`endif
);

  state_e               state_q, state_d;
  logic [SET_WIDTH-1:0] a_q, a_d, b_q, b_d, acc_q, acc_d;
  logic [PTR_WIDTH-1:0] i_q, i_d, j_q, j_d;
  slot_t                sa, sb, acc_slot;
  logic                 in_fire, out_fire;

  rule_set_slot_mux u_mux_a (.set_i(a_q), .idx_i(i_q[RULE_ID_WIDTH-1:0]), .slot_o(sa));
  rule_set_slot_mux u_mux_b (.set_i(b_q), .idx_i(j_q[RULE_ID_WIDTH-1:0]), .slot_o(sb));

  // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      a_q     <= EMPTY_SET;
      b_q     <= EMPTY_SET;
      i_q     <= '0;
      j_q     <= '0;
      acc_q   <= EMPTY_SET;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      i_q     <= i_d;
      j_q     <= j_d;
      acc_q   <= acc_d;
    end
  end

  // NOTE: every output of this block gets a default first, so no path infers a latch.
  always_comb begin
    state_d   = state_q;
    a_d       = a_q;
    b_d       = b_q;
    i_d       = i_q;
    j_d       = j_q;
    acc_d     = acc_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state_q)
      IDLE: begin
        in_ready = !reset;
        if (in_valid) begin
          a_d     = set_a;
          b_d     = set_b;
          i_d     = '0;
          j_d     = '0;
          acc_d   = EMPTY_SET;
          state_d = MERGE;
        end
      end
      MERGE: begin
        // Empty slots are skipped on either side independently.
        if (!sa.valid || !sb.valid) begin
          if (!sa.valid) i_d = i_q + 1'b1;
          if (!sb.valid) j_d = j_q + 1'b1;
        end else if (sa.id < sb.id) begin
          i_d = i_q + 1'b1;
        end else if (sa.id > sb.id) begin
          j_d = j_q + 1'b1;
        end else begin
          acc_d = {acc_q[SET_WIDTH-SLOT_WIDTH-1:0], sa};
          i_d   = i_q + 1'b1;
          j_d   = j_q + 1'b1;
        end
        if (i_d == PTR_END || j_d == PTR_END) state_d = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign in_fire  = in_valid && in_ready;
  assign out_fire = out_valid && out_ready;
  assign out_set  = acc_q;

  // Matches are appended in ascending order, so the first valid slot holds the lowest ID.
  always_comb begin
    best_valid = 1'b0;
    best_id    = '0;
    acc_slot   = '0;
    for (int k = NUM_RULE_ID - 1; k >= 0; k--) begin
      acc_slot = get_slot(acc_q, RULE_ID_WIDTH'(k));
      if (acc_slot.valid) begin
        best_valid = 1'b1;
        best_id    = acc_slot.id;
      end
    end
  end

`ifdef RULE_SET_STATS_EN
  logic [STAT_WIDTH-1:0] stat_pairs_q, stat_nomatch_q;

  always_ff @(posedge clk) begin
    if (reset || stat_clr) begin
      stat_pairs_q   <= '0;
      stat_nomatch_q <= '0;
    end else begin
      if (in_fire && stat_pairs_q != '1)
        stat_pairs_q <= stat_pairs_q + 1'b1;
      if (out_fire && !best_valid && stat_nomatch_q != '1)
        stat_nomatch_q <= stat_nomatch_q + 1'b1;
    end
  end

  assign stat_pairs   = stat_pairs_q;
  assign stat_nomatch = stat_nomatch_q;
`else
  logic unused_fire;
  assign unused_fire = in_fire ^ out_fire;
`endif

endmodule

// File: tb/tb_rule_set_intersect.sv
// Self-checking bench for rule_set_intersect: directed cases plus randomized
// back-to-back pairs checked against a set-level reference model.
module tb_rule_set_intersect;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] set_a, set_b;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_set;
  logic        best_valid;
  logic [2:0]  best_id;
`ifdef RULE_SET_STATS_EN
  logic        stat_clr;
  logic [31:0] stat_pairs, stat_nomatch;
`endif

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  rule_set_intersect dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .set_a     (set_a),
    .set_b     (set_b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_set   (out_set),
    .best_valid(best_valid),
`ifdef RULE_SET_STATS_EN
    .best_id   (best_id),
    .stat_clr  (stat_clr),
    .stat_pairs(stat_pairs),
    .stat_nomatch(stat_nomatch)
`else
    .best_id   (best_id)
`endif
  );

  // Reference model: a set is a bitmask of rule IDs; intersection is bitwise AND.
  function automatic logic [7:0] set_to_mask(input logic [31:0] s);
    logic [7:0] m;
    logic [3:0] sl;
    m = '0;
    for (int k = 0; k < 8; k++) begin
      sl = 4'(s >> (4 * (7 - k)));
      if (sl[3]) m[sl[2:0]] = 1'b1;
    end
    return m;
  endfunction

  function automatic logic [31:0] mask_to_set(input logic [7:0] m);
    logic [31:0] s;
    int          cnt, slot;
    s   = '0;
    cnt = 0;
    for (int id = 0; id < 8; id++) if (m[id]) cnt++;
    slot = 8 - cnt;
    for (int id = 0; id < 8; id++) begin
      if (m[id]) begin
        s[31 - 4 * slot -: 4] = {1'b1, 3'(id)};
        slot++;
      end
    end
    return s;
  endfunction

  function automatic logic [3:0] mask_best(input logic [7:0] m);
    for (int id = 0; id < 8; id++) if (m[id]) return {1'b1, 3'(id)};
    return 4'b0000;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) begin
      n_pass++;
    end else begin
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Presents a pair and returns #1 after the accepting edge.
  task automatic send_pair(input logic [31:0] a, input logic [31:0] b);
    bit ok;
    ok       = 1'b0;
    in_valid = 1'b1;
    set_a    = a;
    set_b    = b;
    for (int c = 0; c < 60; c++) begin
      @(negedge clk);
      if (in_ready) begin
        ok = 1'b1;
        break;
      end
    end
    check("accept_seen", 32'(ok), 32'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  // Counts edges from the accepting edge until out_valid is seen.
  task automatic wait_result(output int lat);
    lat = -1;
    for (int c = 1; c <= 60; c++) begin
      @(posedge clk);
      #1;
      if (out_valid) begin
        lat = c;
        break;
      end
    end
    check("result_seen", 32'(lat > 0), 32'd1);
  endtask

  task automatic check_model(input string tag, input logic [31:0] a, input logic [31:0] b);
    logic [7:0] m;
    logic [3:0] bst;
    m   = set_to_mask(a) & set_to_mask(b);
    bst = mask_best(m);
    check({tag, "_set"},  out_set,          mask_to_set(m));
    check({tag, "_bv"},   32'(best_valid),  32'(bst[3]));
    check({tag, "_bid"},  32'(best_id),     32'(bst[2:0]));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int          lat, bad, sent, got, dup, idx;
    bit          fire;
    int          q[$];
    logic [31:0] a_arr[12], b_arr[12];
    logic [7:0]  ma, mb;

    reset     = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    set_a     = '0;
    set_b     = '0;
`ifdef RULE_SET_STATS_EN
    stat_clr  = 1'b0;
`endif

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_in_ready",  32'(in_ready),   32'd0);
    check("rst_out_valid", 32'(out_valid),  32'd0);
    check("rst_out_set",   out_set,         32'h0);
    check("rst_best_valid",32'(best_valid), 32'd0);
    check("rst_best_id",   32'(best_id),    32'd0);
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("idle_in_ready", 32'(in_ready), 32'd1);

    // {0,2,6,7} & {1,2,6,7}
    send_pair(32'h0000_8AEF, 32'h0000_9AEF);
    wait_result(lat);
    check("t1_latency", 32'(lat),        32'd9);
    check("t1_set",     out_set,         32'h0000_0AEF);
    check("t1_bv",      32'(best_valid), 32'd1);
    check("t1_bid",     32'(best_id),    32'd2);

    // Empty A
    send_pair(32'h0000_0000, 32'h0000_00EF);
    wait_result(lat);
    check("t2_latency", 32'(lat),        32'd8);
    check("t2_set",     out_set,         32'h0);
    check("t2_bv",      32'(best_valid), 32'd0);
    check("t2_bid",     32'(best_id),    32'd0);
    @(posedge clk);
    #1;
`ifdef RULE_SET_STATS_EN
    check("t2_stat_nomatch", stat_nomatch, 32'd1);
    check("t2_stat_pairs",   stat_pairs,   32'd2);
`endif

    // {3,5,6,7} & {7}, then back-pressure with a second pair waiting
    out_ready = 1'b0;
    send_pair(32'h0000_BDEF, 32'h0000_000F);
    wait_result(lat);
    check("t3_set", out_set,         32'h0000_000F);
    check("t3_bv",  32'(best_valid), 32'd1);
    check("t3_bid", 32'(best_id),    32'd7);
    in_valid = 1'b1;
    set_a    = 32'h0000_0CDE;
    set_b    = 32'h0000_0DEF;
    bad      = 0;
    for (int c = 0; c < 20; c++) begin
      @(posedge clk);
      #1;
      if (out_set !== 32'h0000_000F || out_valid !== 1'b1 || in_ready !== 1'b0 ||
          best_id !== 3'd7)
        bad++;
    end
    check("bp_stable", 32'(bad), 32'd0);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    check("bp_idle_out_valid", 32'(out_valid), 32'd0);
    check("bp_idle_in_ready",  32'(in_ready),  32'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    check("bp_accepted", 32'(in_ready), 32'd0);
    wait_result(lat);
    check("bp_set", out_set,      32'h0000_00DE);
    check("bp_bid", 32'(best_id), 32'd5);

    // Reset three clocks into MERGE
    send_pair(32'h89AB_CDEF, 32'h89AB_CDEF);
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b1;
    #1;
    check("mid_rst_in_ready", 32'(in_ready), 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    #1;
    check("mid_rst_out_valid", 32'(out_valid), 32'd0);
    check("mid_rst_out_set",   out_set,         32'h0);
    check("mid_rst_in_ready1", 32'(in_ready),   32'd1);
    send_pair(32'h89AB_CDEF, 32'h89AB_CDEF);
    wait_result(lat);
    check("full_latency", 32'(lat),        32'd8);
    check("full_set",     out_set,         32'h89AB_CDEF);
    check("full_bv",      32'(best_valid), 32'd1);
    check("full_bid",     32'(best_id),    32'd0);
    @(posedge clk);
    #1;

    // Randomized back-to-back pairs with in_valid held high
    for (int k = 0; k < 12; k++) begin
      ma       = 8'($urandom_range(0, 255));
      mb       = ma ^ 8'($urandom_range(0, 255));
      a_arr[k] = mask_to_set(ma);
      b_arr[k] = mask_to_set(mb);
    end
    sent     = 0;
    got      = 0;
    dup      = 0;
    in_valid = 1'b1;
    set_a    = a_arr[0];
    set_b    = b_arr[0];
    for (int cyc = 0; cyc < 1000 && got < 12; cyc++) begin
      @(negedge clk);
      fire = in_valid && in_ready;
      @(posedge clk);
      #1;
      if (fire) begin
        q.push_back(sent);
        sent++;
        if (sent < 12) begin
          set_a = a_arr[sent];
          set_b = b_arr[sent];
        end else begin
          in_valid = 1'b0;
        end
      end
      if (out_valid) begin
        if (q.size() == 0) begin
          dup++;
        end else begin
          idx = q.pop_front();
          check_model($sformatf("b2b%0d", idx), a_arr[idx], b_arr[idx]);
          got++;
        end
      end
    end
    in_valid = 1'b0;
    check("b2b_count", 32'(got),      32'd12);
    check("b2b_dup",   32'(dup),      32'd0);
    check("b2b_left",  32'(q.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
